// File: rtl/mod3_tx.sv
// mod3_tx: MSB-first serializer that tracks the residue mod 3 of the payload
// bits sent so far. Defining MOD3_CHECK_EN adds a CHECK state that appends two
// check bits, so every (WIDTH+2)-bit frame is divisible by 3. Without the
// macro, frames are WIDTH payload bits only.
module mod3_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             bit_out,
    output logic             frame,
    output logic             last,
    output logic [1:0]       residue
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef MOD3_CHECK_EN
    localparam logic [CW-1:0] CNT_CHK1 = CW'(WIDTH + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;   // held word, shifted left as bits leave
    logic [CW-1:0]    cnt_q, cnt_d;     // payload/check bit index within frame
    logic [1:0]       res_q, res_d;     // residue of bits sent so far
    logic             accept;

    // Residue after appending bit b to a value whose residue is r: (2r+b) mod 3.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case ({r, b})
            3'b00_0: n = 2'b00;
            3'b00_1: n = 2'b01;
            3'b01_0: n = 2'b10;
            3'b01_1: n = 2'b00;
            3'b10_0: n = 2'b01;
            3'b10_1: n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

`ifdef MOD3_CHECK_EN
    // Check value c = (3 - r) mod 3; appending it makes 4*payload + c divisible by 3.
    function automatic logic [1:0] check_bits(input logic [1:0] r);
        logic [1:0] c;
        case (r)
            2'b01:   c = 2'b10;
            2'b10:   c = 2'b01;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    logic [1:0] chk;
    assign chk = check_bits(res_q);
`endif

    assign accept  = (state_q == IDLE) && load;
    assign residue = res_q;

    // State register; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: load is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
`ifdef MOD3_CHECK_EN
                    state_d = CHECK;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef MOD3_CHECK_EN
            CHECK: begin
                if (cnt_q == CNT_CHK1) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, shift and fold residue in SHIFT.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        if (accept) begin
            word_d = din;
            cnt_d  = '0;
            res_d  = 2'b00;
        end else if (state_q == SHIFT) begin
            word_d = {word_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
            res_d  = mod3_step(res_q, word_q[WIDTH-1]);
        end
`ifdef MOD3_CHECK_EN
        else if (state_q == CHECK) begin
            cnt_d = cnt_q + CW'(1);
        end
`endif
    end

    // Datapath registers; residue holds outside SHIFT until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= '0;
            res_q  <= 2'b00;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
        end
    end

    // Outputs decoded from registered state so reset clears them without a clock.
    always_comb begin
        ready   = 1'b0;
        bit_out = 1'b0;
        frame   = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                bit_out = word_q[WIDTH-1];
                frame   = 1'b1;
`ifndef MOD3_CHECK_EN
                last    = (cnt_q == CNT_LAST);
`endif
            end
`ifdef MOD3_CHECK_EN
            CHECK: begin
                frame   = 1'b1;
                bit_out = (cnt_q == CNT_CHK1) ? chk[0] : chk[1];
                last    = (cnt_q == CNT_CHK1);
            end
`endif
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mod3_tx.sv
// Directed bench for mod3_tx at WIDTH=8; follows MOD3_CHECK_EN for frame length.
module tb_mod3_tx;

    localparam int W = 8;
`ifdef MOD3_CHECK_EN
    localparam int FL = W + 2;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         load = 1'b0;
    logic         ready, bit_out, frame, last;
    logic [1:0]   residue;

    int nvec = 0;
    int nerr = 0;

    mod3_tx #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .din(din), .load(load),
        .ready(ready), .bit_out(bit_out), .frame(frame), .last(last),
        .residue(residue)
    );

    always #5 clk = ~clk;

    // Payloads, hand-derived residue after each payload bit (2 bits per entry,
    // entry k at [15-2k -: 2]), and check bits.
    localparam logic [7:0]  VDIN [3] = '{8'h06, 8'h07, 8'h05};
    localparam logic [15:0] VRES [3] = '{16'b00_00_00_00_00_01_00_00,
                                         16'b00_00_00_00_00_01_00_01,
                                         16'b00_00_00_00_00_01_10_10};
    localparam logic [1:0]  VCHK [3] = '{2'b00, 2'b10, 2'b01};

    task automatic test_reset();
        #3;
        nvec++; if (ready !== 1'b1)   begin nerr++; $display("FAIL rst_ready got %b want 1", ready); end
        nvec++; if (frame !== 1'b0)   begin nerr++; $display("FAIL rst_frame got %b want 0", frame); end
        nvec++; if (bit_out !== 1'b0) begin nerr++; $display("FAIL rst_bit got %b want 0", bit_out); end
        nvec++; if (last !== 1'b0)    begin nerr++; $display("FAIL rst_last got %b want 0", last); end
        nvec++; if (residue !== 2'b00) begin nerr++; $display("FAIL rst_residue got %b want 00", residue); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frames();
        for (int v = 0; v < 3; v++) begin
            logic [7:0]  pd;
            logic [15:0] rs;
            logic [1:0]  ck;
            logic        eb;
            logic [1:0]  er;
            pd = VDIN[v]; rs = VRES[v]; ck = VCHK[v];
            @(negedge clk);
            din = pd; load = 1'b1;
            @(posedge clk);
            #1 load = 1'b0;
            for (int k = 0; k < FL; k++) begin
                @(negedge clk);
                if (k < W) eb = pd[W-1-k]; else eb = ck[W+1-k];
                if (k == 0) er = 2'b00;
                else if (k <= W) er = rs[15-2*(k-1) -: 2];
                else er = rs[1:0];
                nvec++; if (bit_out !== eb) begin nerr++; $display("FAIL frm%0d_bit%0d got %b want %b", v, k, bit_out, eb); end
                nvec++; if (frame !== 1'b1) begin nerr++; $display("FAIL frm%0d_frame%0d got %b want 1", v, k, frame); end
                nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL frm%0d_ready%0d got %b want 0", v, k, ready); end
                nvec++; if (last !== (k == FL-1)) begin nerr++; $display("FAIL frm%0d_last%0d got %b want %b", v, k, last, (k == FL-1)); end
                nvec++; if (residue !== er) begin nerr++; $display("FAIL frm%0d_res%0d got %b want %b", v, k, residue, er); end
            end
            @(negedge clk);
            nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL frm%0d_idle_ready got %b want 1", v, ready); end
            nvec++; if (frame !== 1'b0 || last !== 1'b0 || bit_out !== 1'b0) begin
                nerr++; $display("FAIL frm%0d_idle_outs got f%b l%b b%b want 000", v, frame, last, bit_out);
            end
            nvec++; if (residue !== rs[1:0]) begin nerr++; $display("FAIL frm%0d_final_res got %b want %b", v, residue, rs[1:0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa;
        logic [7:0] pb;
        logic       eb;
        pa = 8'hFF; pb = 8'hA5;
        @(negedge clk);
        din = pa; load = 1'b1;
        @(posedge clk);
        #1 din = pb;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            eb = (k < W) ? pa[W-1-k] : 1'b0;
            nvec++; if (bit_out !== eb || frame !== 1'b1 || ready !== 1'b0) begin
                nerr++; $display("FAIL b2b_a%0d got b%b f%b r%b want b%b f1 r0", k, bit_out, frame, ready, eb);
            end
            nvec++; if (last !== (k == FL-1)) begin nerr++; $display("FAIL b2b_a_last%0d got %b want %b", k, last, (k == FL-1)); end
        end
        @(negedge clk);
        nvec++; if (ready !== 1'b1 || frame !== 1'b0) begin nerr++; $display("FAIL b2b_gap got r%b f%b want r1 f0", ready, frame); end
        nvec++; if (residue !== 2'b00) begin nerr++; $display("FAIL b2b_res_a got %b want 00", residue); end
        @(posedge clk);
        #1 load = 1'b0;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            eb = (k < W) ? pb[W-1-k] : 1'b0;
            nvec++; if (bit_out !== eb || frame !== 1'b1) begin
                nerr++; $display("FAIL b2b_b%0d got b%b f%b want b%b f1", k, bit_out, frame, eb);
            end
            nvec++; if (last !== (k == FL-1)) begin nerr++; $display("FAIL b2b_b_last%0d got %b want %b", k, last, (k == FL-1)); end
        end
        @(negedge clk);
        nvec++; if (residue !== 2'b00 || ready !== 1'b1) begin nerr++; $display("FAIL b2b_res_b got res%b r%b want res00 r1", residue, ready); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] pc;
        pc = 8'h01;
        @(negedge clk);
        din = 8'hFF; load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (4) @(negedge clk);
        // Now on bit 4 (k=3): three ones sent, residue 7 mod 3 = 1.
        nvec++; if (bit_out !== 1'b1 || residue !== 2'b01) begin
            nerr++; $display("FAIL mid_pre got b%b res%b want b1 res01", bit_out, residue);
        end
        #2 reset = 1'b0;
        #1;
        nvec++; if (bit_out !== 1'b0 || frame !== 1'b0 || last !== 1'b0) begin
            nerr++; $display("FAIL mid_async_outs got b%b f%b l%b want 000", bit_out, frame, last);
        end
        nvec++; if (residue !== 2'b00) begin nerr++; $display("FAIL mid_async_res got %b want 00", residue); end
        nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL mid_async_ready got %b want 1", ready); end
        @(posedge clk);
        #1;
        nvec++; if (frame !== 1'b0 || last !== 1'b0) begin nerr++; $display("FAIL mid_held got f%b l%b want 00", frame, last); end
        @(negedge clk);
        reset = 1'b1; din = pc; load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            nvec++; if (bit_out !== pc[W-1-k] || frame !== 1'b1) begin
                nerr++; $display("FAIL post_bit%0d got b%b f%b want b%b f1", k, bit_out, frame, pc[W-1-k]);
            end
            nvec++; if (last !== ((FL == W) && (k == W-1))) begin
                nerr++; $display("FAIL post_last%0d got %b want %b", k, last, ((FL == W) && (k == W-1)));
            end
        end
        repeat (FL - W + 1) @(negedge clk);
        nvec++; if (residue !== 2'b01 || ready !== 1'b1) begin nerr++; $display("FAIL post_res got res%b r%b want res01 r1", residue, ready); end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
